// File: rtl/cntlz_decode64_pkg.sv
// Shared constants, mode encodings and fill helpers for the count-to-pattern
// decoder that sits beside cntlz64/cntlo64.
package cntlz_decode64_pkg;

   localparam int DATA_W     = 64;
   localparam int CNT_W      = 7;
   localparam int BYTE_CNT_W = 3;
   localparam logic [CNT_W-1:0] MAX_CNT = 7'd64;

   // cntlz64/cntlo64 report 64 for an all-zero / all-one word.
   localparam int CNTLZ_W = 7;
   localparam int CNTLO_W = 7;

   typedef enum logic [1:0] {
      MODE_ONEHOT   = 2'd0,
      MODE_LOWMASK  = 2'd1,
      MODE_LEADONES = 2'd2,
      MODE_RSVD     = 2'd3
   } mode_e;

   function automatic mode_e norm_mode(input logic [1:0] m);
      return (m == 2'd3) ? MODE_ONEHOT : mode_e'(m);
   endfunction

   function automatic logic [7:0] fill_hi(input mode_e m);
      return (m == MODE_LEADONES) ? 8'hFF : 8'h00;
   endfunction

   function automatic logic [7:0] fill_lo(input mode_e m);
      return (m == MODE_LOWMASK) ? 8'hFF : 8'h00;
   endfunction

   // Word produced for a clamped count of 64.
   function automatic logic [DATA_W-1:0] full_word(input mode_e m);
      return (m == MODE_LEADONES) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
   endfunction

endpackage

// File: rtl/cntlz_decode64_if.sv
// Input and output valid/ready channels of the count-to-pattern decoder.
interface cntlz_decode64_if;
   import cntlz_decode64_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [CNT_W-1:0]  in_cnt;
   logic [1:0]        in_mode;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_sat;

   modport master (
      output in_valid, in_cnt, in_mode, out_ready,
      input  in_ready, out_valid, out_data, out_sat
   );

   modport slave (
      input  in_valid, in_cnt, in_mode, out_ready,
      output in_ready, out_valid, out_data, out_sat
   );

endinterface

// File: rtl/cntlz_decode64_decode8.sv
// Byte-local inverse of cntlz8: 3-bit count and mode to an 8-bit pattern.
module cntlz_decode8
   import cntlz_decode64_pkg::*;
(
   input  logic [BYTE_CNT_W-1:0] cnt,
   input  mode_e                 mode,
   output logic [7:0]            pat
);

   always_comb begin
      pat = 8'h80 >> cnt;
      case (mode)
         MODE_LOWMASK:  pat = 8'hFF >> cnt;
         MODE_LEADONES: pat = ~(8'hFF >> cnt);
         default:       pat = 8'h80 >> cnt;
      endcase
   end

endmodule

// File: rtl/cntlz_decode64.sv
// Two-stage count-to-pattern decoder: S1 builds the byte-local pattern,
// S2 assembles the 64-bit word. Valid/ready on both sides.
module cntlz_decode64
   import cntlz_decode64_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   cntlz_decode64_if.slave    bus
);

   logic                  sat_in;
   logic [CNT_W-1:0]      n_clamped;
   mode_e                 mode_in;
   logic [7:0]            pat_in;

   logic                  s1_valid_reg;
   logic [BYTE_CNT_W-1:0] s1_byte_reg;
   logic [7:0]            s1_pat_reg;
   logic                  s1_is64_reg;
   mode_e                 s1_mode_reg;
   logic                  s1_sat_reg;

   logic                  out_valid_reg;
   logic [DATA_W-1:0]     out_data_reg;
   logic                  out_sat_reg;

   logic                  adv1;
   logic                  adv2;
   logic [DATA_W-1:0]     word_asm;
   logic [DATA_W-1:0]     word_next;

   assign sat_in    = (bus.in_cnt > MAX_CNT);
   assign n_clamped = sat_in ? MAX_CNT : bus.in_cnt;
   assign mode_in   = norm_mode(bus.in_mode);

   cntlz_decode8 u_decode8 (
      .cnt  (n_clamped[2:0]),
      .mode (mode_in),
      .pat  (pat_in)
   );

   assign adv2 = !out_valid_reg || bus.out_ready;
   assign adv1 = !s1_valid_reg || adv2;

   // Lane gi is the gi-th byte counted from the MSB, matching n[5:3].
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_lane
         assign word_asm[DATA_W-1-8*gi -: 8] =
            (3'(gi) < s1_byte_reg)  ? fill_hi(s1_mode_reg) :
            (3'(gi) == s1_byte_reg) ? s1_pat_reg :
                                      fill_lo(s1_mode_reg);
      end
   endgenerate

   assign word_next = s1_is64_reg ? full_word(s1_mode_reg) : word_asm;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_reg  <= 1'b0;
         s1_byte_reg   <= '0;
         s1_pat_reg    <= '0;
         s1_is64_reg   <= 1'b0;
         s1_mode_reg   <= MODE_ONEHOT;
         s1_sat_reg    <= 1'b0;
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         out_sat_reg   <= 1'b0;
      end else if (clr) begin
         s1_valid_reg  <= 1'b0;
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         out_sat_reg   <= 1'b0;
      end else begin
         if (adv1) begin
            s1_valid_reg <= bus.in_valid;
         end
         if (adv1 && bus.in_valid) begin
            s1_byte_reg <= n_clamped[5:3];
            s1_pat_reg  <= pat_in;
            s1_is64_reg <= n_clamped[6];
            s1_mode_reg <= mode_in;
            s1_sat_reg  <= sat_in;
         end
         if (adv2) begin
            out_valid_reg <= s1_valid_reg;
         end
         if (adv2 && s1_valid_reg) begin
            out_data_reg <= word_next;
            out_sat_reg  <= s1_sat_reg;
         end
      end
   end

   assign bus.in_ready  = adv1;
   assign bus.out_valid = out_valid_reg;
   assign bus.out_data  = out_data_reg;
   assign bus.out_sat   = out_sat_reg;

endmodule
